// File: rtl/boot_loader_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// boot_loader_ctrl_pkg
// Shared definitions for the boot loader controller: default data/address
// widths and the loader FSM state encoding. State names carry a BL_ prefix
// so they never collide with the control-unit state names.
// ----------------------------------------------------------------------------
package boot_loader_ctrl_pkg;

   localparam int unsigned BL_REGISTER_WIDTH       = 4;
   localparam int unsigned BL_MEMORY_ADDRESS_WIDTH = 4;

   typedef enum logic [2:0] {
      BL_IDLE  = 3'd0,
      BL_REQ   = 3'd1,
      BL_WAIT  = 3'd2,
      BL_WRITE = 3'd3,
      BL_DONE  = 3'd4
   } bl_state_t;

   // States in which the control unit must be held in its programming state.
   function automatic logic bl_is_programming(input bl_state_t s);
      return (s == BL_REQ) || (s == BL_WAIT) || (s == BL_WRITE);
   endfunction

endpackage

// File: rtl/boot_loader_ctrl_strb_edge_detect.sv
// ----------------------------------------------------------------------------
// strb_edge_detect
// Rising-edge detector for the already-synchronized data strobe button.
//   clk_i    : clock
//   reset_i  : synchronous active-high reset (clears the previous-value reg)
//   strb_i   : strobe level
//   edge_o   : high for one cycle when strb_i is 1 and was 0 last cycle
// The previous-value register updates every cycle regardless of who uses
// the pulse, so edges seen while nobody listens are simply lost.
// ----------------------------------------------------------------------------
module strb_edge_detect (
   input  logic clk_i,
   input  logic reset_i,
   input  logic strb_i,
   output logic edge_o
);

   logic strb_prev;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         strb_prev <= 1'b0;
      end else begin
         strb_prev <= strb_i;
      end
   end

   assign edge_o = strb_i & ~strb_prev;

endmodule

// File: rtl/boot_loader_ctrl.sv
// ----------------------------------------------------------------------------
// boot_loader_ctrl
// Loads program memory from board switches. A session asks the control unit
// to enter its programming state, then writes one nibble per button press to
// consecutive addresses until address 15 is written or end_i is raised.
//   clk_i             : clock
//   reset_i           : synchronous active-high reset
//   start_i           : request a session (sampled in IDLE only)
//   end_i             : finish session early (sampled in WAIT only)
//   data_i            : nibble from switches
//   data_strb_i       : synchronized button; rising edge = data_i valid
//   p_active_i        : control unit acknowledges programming state
//   p_programm_o      : request programming state from control unit
//   p_write_en_mem_o  : one-cycle memory write enable
//   p_address_o       : write address (address counter, also LEDs)
//   p_data_o          : write data (latched nibble)
//   busy_o            : high in every state except IDLE
//   done_o            : one-cycle pulse when a session ends normally
// ----------------------------------------------------------------------------
module boot_loader_ctrl
   import boot_loader_ctrl_pkg::*;
#(
   parameter int unsigned REGISTER_WIDTH       = BL_REGISTER_WIDTH,
   parameter int unsigned MEMORY_ADDRESS_WIDTH = BL_MEMORY_ADDRESS_WIDTH
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic                            start_i,
   input  logic                            end_i,
   input  logic [REGISTER_WIDTH-1:0]       data_i,
   input  logic                            data_strb_i,
   input  logic                            p_active_i,
   output logic                            p_programm_o,
   output logic                            p_write_en_mem_o,
   output logic [MEMORY_ADDRESS_WIDTH-1:0] p_address_o,
   output logic [REGISTER_WIDTH-1:0]       p_data_o,
   output logic                            busy_o,
   output logic                            done_o
);

   bl_state_t                       state;
   logic [MEMORY_ADDRESS_WIDTH-1:0] addr_cnt;
   logic [REGISTER_WIDTH-1:0]       data_reg;
   logic                            strb_edge;

   strb_edge_detect u_strb_edge_detect (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .strb_i  (data_strb_i),
      .edge_o  (strb_edge)
   );

   // Outputs are registered alongside the state: each transition drives the
   // output values belonging to the state being entered.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state            <= BL_IDLE;
         addr_cnt         <= '0;
         data_reg         <= '0;
         p_programm_o     <= 1'b0;
         p_write_en_mem_o <= 1'b0;
         busy_o           <= 1'b0;
         done_o           <= 1'b0;
      end else begin
         p_write_en_mem_o <= 1'b0;
         done_o           <= 1'b0;
         case (state)
            BL_IDLE: begin
               if (start_i) begin
                  state        <= BL_REQ;
                  addr_cnt     <= '0;
                  p_programm_o <= bl_is_programming(BL_REQ);
                  busy_o       <= 1'b1;
               end
            end
            BL_REQ: begin
               if (p_active_i) begin
                  state <= BL_WAIT;
               end
            end
            BL_WAIT: begin
               // end_i has priority: a coincident strobe nibble is dropped.
               if (end_i) begin
                  state        <= BL_DONE;
                  p_programm_o <= bl_is_programming(BL_DONE);
                  done_o       <= 1'b1;
               end else if (strb_edge) begin
                  state            <= BL_WRITE;
                  data_reg         <= data_i;
                  p_write_en_mem_o <= 1'b1;
               end
            end
            BL_WRITE: begin
               addr_cnt <= addr_cnt + 1'b1;
               if (addr_cnt == '1) begin
                  state        <= BL_DONE;
                  p_programm_o <= bl_is_programming(BL_DONE);
                  done_o       <= 1'b1;
               end else begin
                  state <= BL_WAIT;
               end
            end
            BL_DONE: begin
               state  <= BL_IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state        <= BL_IDLE;
               p_programm_o <= 1'b0;
               busy_o       <= 1'b0;
            end
         endcase
      end
   end

   assign p_address_o = addr_cnt;
   assign p_data_o    = data_reg;

endmodule
